// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for one mem_arbiter port (instruction or data cache).
// The cache drives the master side; the arbiter takes the slave side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int BLK_W  = 256
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [BLK_W-1:0]  wdata;
  logic              done;
  logic [BLK_W-1:0]  rdata;

  modport master (output req, we, addr, wdata, input done, rdata);
  modport slave  (input req, we, addr, wdata, output done, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the shared 256-bit block memory.
// Define MEMARB_FIXED_PRIO_EN for fixed data-cache priority; default is round robin.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int BLK_W  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_arbiter_if.slave      ip,
  mem_arbiter_if.slave      dp,
  output logic              blockread,
  output logic              blockwrite,
  output logic [ADDR_W-1:0] blockaddr,
  output logic [BLK_W-1:0]  writeblock,
  input  logic [BLK_W-1:0]  readblock,
  input  logic              ready
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE} state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;       // port being served: 0 = icache, 1 = dcache
  logic              blockread_d, blockwrite_d;
  logic [ADDR_W-1:0] blockaddr_d;
  logic [BLK_W-1:0]  writeblock_d;
  logic              i_done_q, i_done_d, d_done_q, d_done_d;
  logic [BLK_W-1:0]  i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              grant;
  logic              winner;

  // A new grant waits for the memory to be idle, which also covers a read
  // still counting down after a mid-operation reset.
  assign grant = (state_q == IDLE) && ready && (ip.req || dp.req);

`ifdef MEMARB_FIXED_PRIO_EN
  assign winner = dp.req;
`else
  logic last_grant_q;

  assign winner = (ip.req && dp.req) ? ~last_grant_q : dp.req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   last_grant_q <= 1'b1;
    else if (grant) last_grant_q <= winner;
  end
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    gnt_d        = gnt_q;
    blockread_d  = blockread;
    blockwrite_d = blockwrite;
    blockaddr_d  = blockaddr;
    writeblock_d = writeblock;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          gnt_d        = winner;
          blockaddr_d  = winner ? dp.addr  : ip.addr;
          writeblock_d = winner ? dp.wdata : ip.wdata;
          if (winner ? dp.we : ip.we) begin
            blockwrite_d = 1'b1;
            state_d      = WR_ISSUE;
          end else begin
            blockread_d = 1'b1;
            state_d     = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        if (!ready) begin
          blockread_d = 1'b0;
          state_d     = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (ready) begin
          if (gnt_q) begin
            d_rdata_d = readblock;
            d_done_d  = 1'b1;
          end else begin
            i_rdata_d = readblock;
            i_done_d  = 1'b1;
          end
          state_d = DONE;
        end
      end
      WR_ISSUE: begin
        blockwrite_d = 1'b0;
        if (gnt_q) d_done_d = 1'b1;
        else       i_done_d = 1'b1;
        state_d = DONE;
      end
      // Turnaround cycle lets the requester drop req before IDLE re-arbitrates.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      blockread  <= 1'b0;
      blockwrite <= 1'b0;
      blockaddr  <= '0;
      writeblock <= '0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      // NOTE: the wide data registers are plain flops, not a RAM, so they take the reset too.
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      blockread  <= blockread_d;
      blockwrite <= blockwrite_d;
      blockaddr  <= blockaddr_d;
      writeblock <= writeblock_d;
      i_done_q   <= i_done_d;
      d_done_q   <= d_done_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign ip.done  = i_done_q;
  assign dp.done  = d_done_q;
  assign ip.rdata = i_rdata_q;
  assign dp.rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: 5-count block memory model, per-port
// scoreboard queues, and negedge monitors for grants, strobes and done pulses.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int BLK_W  = 256;
  localparam int NBLK   = 64;

  typedef struct {
    logic             we;
    logic [BLK_W-1:0] data;
  } exp_t;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic              blockread, blockwrite;
  logic [ADDR_W-1:0] blockaddr;
  logic [BLK_W-1:0]  writeblock, readblock;
  logic              ready = 1'b1;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .BLK_W(BLK_W)) ip_if ();
  mem_arbiter_if #(.ADDR_W(ADDR_W), .BLK_W(BLK_W)) dp_if ();

  mem_arbiter #(.ADDR_W(ADDR_W), .BLK_W(BLK_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ip         (ip_if),
    .dp         (dp_if),
    .blockread  (blockread),
    .blockwrite (blockwrite),
    .blockaddr  (blockaddr),
    .writeblock (writeblock),
    .readblock  (readblock),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model: 64-bit words, four per block ----------------
  logic [63:0] mem_w [NBLK*4];
  logic [63:0] ref_w [NBLK*4];
  int          mem_cnt = 0;

  function automatic logic [63:0] preload(input int k);
    logic [31:0] kk;
    kk = k;
    return {32'hC0DE_0000 + kk, 32'h5EED_0000 + kk};
  endfunction

  initial begin
    for (int k = 0; k < NBLK*4; k++) begin
      mem_w[k] = preload(k);
      ref_w[k] = preload(k);
    end
  end

  always_comb begin
    readblock = '0;
    for (int j = 0; j < 4; j++)
      readblock[j*64 +: 64] = mem_w[{blockaddr[5:0], 2'(j)}];
  end

  always @(negedge clk) begin
    if (blockwrite)
      for (int j = 0; j < 4; j++)
        mem_w[{blockaddr[5:0], 2'(j)}] <= writeblock[j*64 +: 64];
    if (ready && blockread) begin
      ready   <= 1'b0;
      mem_cnt <= 5;
    end else if (!ready) begin
      mem_cnt <= mem_cnt - 1;
      if (mem_cnt == 1) ready <= 1'b1;
    end
  end

  function automatic logic [BLK_W-1:0] ref_block(input logic [5:0] a);
    logic [BLK_W-1:0] b;
    for (int j = 0; j < 4; j++) b[j*64 +: 64] = ref_w[{a, 2'(j)}];
    return b;
  endfunction

  // ---------------- monitors ----------------
  logic              prev_br = 1'b0, prev_bw = 1'b0;
  logic [ADDR_W-1:0] grant_log [$];
  int grant_cyc = 0, done_cyc0 = 0, done_cyc1 = 0;
  int done_cnt0 = 0, done_cnt1 = 0;
  int overlap_cnt = 0, busy_grant_cnt = 0, rd_hi_cnt = 0, wr_hi_cnt = 0;

  always @(negedge clk) begin
    if ((blockread && !prev_br) || (blockwrite && !prev_bw)) begin
      grant_log.push_back(blockaddr);
      grant_cyc = cyc;
      if (!ready) busy_grant_cnt++;
    end
    if (blockread)               rd_hi_cnt++;
    if (blockwrite)              wr_hi_cnt++;
    if (blockread && blockwrite) overlap_cnt++;
    if (ip_if.done) begin done_cnt0++; done_cyc0 = cyc; end
    if (dp_if.done) begin done_cnt1++; done_cyc1 = cyc; end
    prev_br = blockread;
    prev_bw = blockwrite;
  end

  // ---------------- scoreboard and requester tasks ----------------
  exp_t q0 [$];
  exp_t q1 [$];

  task automatic start_req(input bit p, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [BLK_W-1:0] wdata);
    exp_t e;
    @(posedge clk); #1;
    e.we = we;
    if (we) begin
      for (int j = 0; j < 4; j++) ref_w[{addr[5:0], 2'(j)}] = wdata[j*64 +: 64];
      e.data = '0;
    end else begin
      e.data = ref_block(addr[5:0]);
    end
    if (!p) begin
      ip_if.we = we; ip_if.addr = addr; ip_if.wdata = wdata; ip_if.req = 1'b1;
      q0.push_back(e);
    end else begin
      dp_if.we = we; dp_if.addr = addr; dp_if.wdata = wdata; dp_if.req = 1'b1;
      q1.push_back(e);
    end
  endtask

  task automatic finish_req(input bit p);
    bit               seen;
    bit               have;
    exp_t             e;
    logic [BLK_W-1:0] got;
    seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if ((p ? dp_if.done : ip_if.done) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout port=%0d: no done within 300 cycles, required one done pulse", p);
    end else begin
      have = 1'b0;
      if (!p && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (p && q1.size() > 0)  begin e = q1.pop_front(); have = 1'b1; end
      got = p ? dp_if.rdata : ip_if.rdata;
      if (!have) begin
        failures++;
        $display("FAIL unexpected_done port=%0d: done with empty scoreboard, required none", p);
      end else if (!e.we) begin
        checks++;
        if (got !== e.data) begin
          failures++;
          $display("FAIL rdata port=%0d: got %h required %h", p, got, e.data);
        end
      end
    end
    if (!p) ip_if.req = 1'b0;
    else    dp_if.req = 1'b0;
    #1;
  endtask

  task automatic run_req(input bit p, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [BLK_W-1:0] wdata);
    start_req(p, we, addr, wdata);
    finish_req(p);
  endtask

  task automatic apply_reset();
    @(negedge clk) reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({blockread, blockwrite, ip_if.done, dp_if.done} !== 4'b0) begin
      failures++;
      $display("FAIL reset_strobes: got %b required 0000",
               {blockread, blockwrite, ip_if.done, dp_if.done});
    end
    checks++;
    if (blockaddr !== '0) begin
      failures++; $display("FAIL reset_blockaddr: got %h required 0", blockaddr);
    end
    checks++;
    if (writeblock !== '0) begin
      failures++; $display("FAIL reset_writeblock: got %h required 0", writeblock);
    end
    checks++;
    if (ip_if.rdata !== '0 || dp_if.rdata !== '0) begin
      failures++;
      $display("FAIL reset_rdata: got i=%h d=%h required 0", ip_if.rdata, dp_if.rdata);
    end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    int               rd0;
    logic [BLK_W-1:0] exp_blk;
    for (int j = 0; j < 4; j++) exp_blk[j*64 +: 64] = preload(12 + j);
    rd0 = rd_hi_cnt;
    grant_log.delete();
    run_req(1'b0, 1'b0, 3, '0);
    checks++;
    if (grant_log.size() != 1 || grant_log[0] !== 3) begin
      failures++;
      $display("FAIL read_blockaddr: got %0d grants first=%0d, required 1 grant at 3",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 0);
    end
    checks++;
    if (rd_hi_cnt - rd0 != 1) begin
      failures++; $display("FAIL read_strobe_len: got %0d cycles required 1", rd_hi_cnt - rd0);
    end
    checks++;
    if (done_cyc0 - grant_cyc != 6) begin
      failures++; $display("FAIL read_latency: got %0d required 6", done_cyc0 - grant_cyc);
    end
    checks++;
    if (ip_if.rdata !== exp_blk) begin
      failures++; $display("FAIL read_words_12_15: got %h required %h", ip_if.rdata, exp_blk);
    end
  endtask

  task automatic test_single_write();
    int               wr0;
    logic [BLK_W-1:0] pat;
    pat = {32{8'hA5}};
    wr0 = wr_hi_cnt;
    grant_log.delete();
    run_req(1'b1, 1'b1, 5, pat);
    checks++;
    if (wr_hi_cnt - wr0 != 1) begin
      failures++; $display("FAIL write_strobe_len: got %0d cycles required 1", wr_hi_cnt - wr0);
    end
    checks++;
    if (done_cyc1 - grant_cyc != 1) begin
      failures++; $display("FAIL write_latency: got %0d required 1", done_cyc1 - grant_cyc);
    end
    checks++;
    if (grant_log.size() != 1 || grant_log[0] !== 5) begin
      failures++; $display("FAIL write_blockaddr: got %0d grants, required 1 grant at 5", grant_log.size());
    end
    run_req(1'b1, 1'b0, 5, '0);
    checks++;
    if (dp_if.rdata !== pat) begin
      failures++; $display("FAIL write_readback: got %h required %h", dp_if.rdata, pat);
    end
  endtask

  task automatic test_contention();
    logic [ADDR_W-1:0] exp_order [6];
    for (int r = 0; r < 6; r++) begin
`ifdef MEMARB_FIXED_PRIO_EN
      exp_order[r] = (r % 2 == 0) ? 2 : 1;
`else
      exp_order[r] = (r % 2 == 0) ? 1 : 2;
`endif
    end
    apply_reset();
    grant_log.delete();
    for (int r = 0; r < 3; r++) begin
      fork
        run_req(1'b0, 1'b0, 1, '0);
        run_req(1'b1, 1'b0, 2, '0);
      join
    end
    checks++;
    if (grant_log.size() != 6) begin
      failures++; $display("FAIL contention_count: got %0d grants required 6", grant_log.size());
    end else begin
      for (int r = 0; r < 6; r++) begin
        checks++;
        if (grant_log[r] !== exp_order[r]) begin
          failures++;
          $display("FAIL contention_order[%0d]: got %0d required %0d", r, grant_log[r], exp_order[r]);
        end
      end
    end
  endtask

  task automatic test_busy_request();
    int first_done;
    int d_grant;
    int busy0;
    first_done = 0;
    d_grant    = 0;
    busy0      = busy_grant_cnt;
    grant_log.delete();
    fork
      begin
        run_req(1'b0, 1'b0, 7, '0);
        first_done = done_cyc0;
        run_req(1'b0, 1'b0, 8, '0);
      end
      begin
        repeat (2) @(posedge clk);
        run_req(1'b1, 1'b0, 40, '0);
        d_grant = grant_cyc;
      end
    join
    checks++;
    if (grant_log.size() != 3 || grant_log[0] !== 7 || grant_log[1] !== 40 || grant_log[2] !== 8) begin
      failures++;
      $display("FAIL busy_order: got %0d grants, required order 7,40,8", grant_log.size());
    end
    checks++;
    if (d_grant - first_done != 2) begin
      failures++; $display("FAIL busy_grant_delay: got %0d required 2", d_grant - first_done);
    end
    checks++;
    if (busy_grant_cnt != busy0) begin
      failures++; $display("FAIL busy_strobe_while_not_ready: got %0d required 0", busy_grant_cnt - busy0);
    end
  endtask

  task automatic test_reset_midop();
    int busy0;
    busy0 = busy_grant_cnt;
    start_req(1'b0, 1'b0, 9, '0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({blockread, blockwrite, blockaddr, writeblock, ip_if.done, dp_if.done,
         ip_if.rdata, dp_if.rdata} !== '0) begin
      failures++;
      $display("FAIL midop_reset_outputs: got br=%b bw=%b addr=%h i_rdata=%h, required all 0",
               blockread, blockwrite, blockaddr, ip_if.rdata);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    finish_req(1'b0);
    checks++;
    if (busy_grant_cnt != busy0) begin
      failures++;
      $display("FAIL midop_grant_while_busy: got %0d early grants required 0", busy_grant_cnt - busy0);
    end
  endtask

  task automatic test_random();
    int d0, d1, ov0, busy0;
    d0 = done_cnt0; d1 = done_cnt1; ov0 = overlap_cnt; busy0 = busy_grant_cnt;
    fork
      for (int n = 0; n < 25; n++) begin
        logic [BLK_W-1:0] wd;
        for (int j = 0; j < 8; j++) wd[j*32 +: 32] = $urandom();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        run_req(1'b0, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)), wd);
      end
      for (int n = 0; n < 25; n++) begin
        logic [BLK_W-1:0] wd;
        for (int j = 0; j < 8; j++) wd[j*32 +: 32] = $urandom();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        run_req(1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(32, 63)), wd);
      end
    join
    checks++;
    if (done_cnt0 - d0 != 25 || done_cnt1 - d1 != 25) begin
      failures++;
      $display("FAIL random_done_count: got i=%0d d=%0d required 25 each", done_cnt0 - d0, done_cnt1 - d1);
    end
    checks++;
    if (overlap_cnt != ov0) begin
      failures++; $display("FAIL random_strobe_overlap: got %0d cycles required 0", overlap_cnt - ov0);
    end
    checks++;
    if (busy_grant_cnt != busy0) begin
      failures++; $display("FAIL random_grant_while_busy: got %0d required 0", busy_grant_cnt - busy0);
    end
  endtask

  initial begin
    ip_if.req = 1'b0; ip_if.we = 1'b0; ip_if.addr = '0; ip_if.wdata = '0;
    dp_if.req = 1'b0; dp_if.we = 1'b0; dp_if.addr = '0; dp_if.wdata = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_busy_request();
    test_reset_midop();
    test_random();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending required 0/0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
